// File: rtl/alu4_issue_stage_pkg.sv
// Shared op codes, FSM states and flag bit positions for the 4-bit ALU issue stage.
package alu4_issue_stage_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_NOT = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;
  localparam logic [2:0] ALU_OR  = 3'b100;
  localparam logic [2:0] ALU_XOR = 3'b101;
  localparam logic [2:0] ALU_SLT = 3'b110;
  localparam logic [2:0] ALU_EQ  = 3'b111;

  localparam int FLG_Z = 3;
  localparam int FLG_V = 2;
  localparam int FLG_C = 1;
  localparam int FLG_S = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  // Subtract-based ops need a +1 carry-in for two's-complement negation of b.
  function automatic logic cin_for_op(input logic [2:0] op, input logic use_carry,
                                      input logic carry_flag);
    logic cin;
    cin = 1'b0;
    case (op)
      ALU_ADD:                  cin = use_carry & carry_flag;
      ALU_SUB, ALU_SLT, ALU_EQ: cin = 1'b1;
      default:                  cin = 1'b0;
    endcase
    return cin;
  endfunction

endpackage

// File: rtl/alu4_regfile.sv
// NREG x 4 register file: two async read ports, one sync write port, r0 hardwired to zero.
module alu4_regfile #(
  parameter int NREG = 8,
  parameter logic [3:0] REG_RST = 4'h0,
  localparam int RW = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [RW-1:0] ra_addr,
  output logic [3:0]    ra_data,
  input  logic [RW-1:0] rb_addr,
  output logic [3:0]    rb_data,
  input  logic          wr_en,
  input  logic [RW-1:0] wr_addr,
  input  logic [3:0]    wr_data
);

  logic [3:0] regs [NREG];

  always_ff @(posedge clk) begin
    if (rst) begin
      regs[0] <= 4'h0;
      for (int i = 1; i < NREG; i++) begin
        regs[i] <= REG_RST;
      end
    end else if (wr_en && (wr_addr != '0)) begin
      regs[wr_addr] <= wr_data;
    end
  end

  assign ra_data = (ra_addr == '0) ? 4'h0 : regs[ra_addr];
  assign rb_data = (rb_addr == '0) ? 4'h0 : regs[rb_addr];

endmodule

// File: rtl/alu4_issue_stage.sv
// Command front-end for the 4-bit ALU: accept -> issue (1 cycle) -> response, one command in flight.
// Response appears 2 cycles after accept and holds until rsp_ready; no new command is taken meanwhile.
module alu4_issue_stage
  import alu4_issue_stage_pkg::*;
#(
  parameter int NREG = 8,
  parameter logic [3:0] REG_RST = 4'h0,
  localparam int RW = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [RW-1:0] cmd_rd,
  input  logic [RW-1:0] cmd_rs1,
  input  logic [RW-1:0] cmd_rs2,
  input  logic          cmd_imm_en,
  input  logic [3:0]    cmd_imm,
  input  logic          cmd_use_carry,
  input  logic          cmd_wb_en,
  output logic [3:0]    alu_a,
  output logic [3:0]    alu_b,
  output logic [2:0]    alu_c,
  output logic          alu_cin,
  input  logic [3:0]    alu_result,
  input  logic          alu_zero,
  input  logic          alu_overflow,
  input  logic          alu_carry,
  input  logic          alu_size,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [3:0]    rsp_result,
  output logic [3:0]    rsp_flags
);

  state_t        state_q, state_d;
  logic          accept;
  logic [RW-1:0] rd_q;
  logic          wb_q;
  logic [3:0]    flags_q;
  logic [3:0]    rs1_data, rs2_data;
  logic          rf_wr_en;
  // Zero is derived locally from the captured result, so the ALU's own zero is not consumed.
  logic          alu_zero_unused;

  assign alu_zero_unused = alu_zero;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_RESP;
      ST_RESP:  if (rsp_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign cmd_ready = (state_q == ST_IDLE) && !rst;
  assign accept    = cmd_valid && cmd_ready;
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_flags = flags_q;

  alu4_regfile #(
    .NREG    (NREG),
    .REG_RST (REG_RST)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .ra_addr (cmd_rs1),
    .ra_data (rs1_data),
    .rb_addr (cmd_rs2),
    .rb_data (rs2_data),
    .wr_en   (rf_wr_en),
    .wr_addr (rd_q),
    .wr_data (alu_result)
  );

  assign rf_wr_en = (state_q == ST_ISSUE) && wb_q;

  // Operands are latched on accept and held on the ALU until the next accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a   <= 4'h0;
      alu_b   <= 4'h0;
      alu_c   <= 3'b000;
      alu_cin <= 1'b0;
      rd_q    <= '0;
      wb_q    <= 1'b0;
    end else if (accept) begin
      alu_a   <= rs1_data;
      alu_b   <= cmd_imm_en ? cmd_imm : rs2_data;
      alu_c   <= cmd_op;
      alu_cin <= cin_for_op(cmd_op, cmd_use_carry, flags_q[FLG_C]);
      rd_q    <= cmd_rd;
      wb_q    <= cmd_wb_en;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_result <= REG_RST;
      flags_q    <= 4'h0;
    end else if (state_q == ST_ISSUE) begin
      rsp_result     <= alu_result;
      flags_q[FLG_Z] <= ~|alu_result;
      case (alu_c)
        ALU_ADD, ALU_SUB: begin
          flags_q[FLG_C] <= alu_carry;
          flags_q[FLG_V] <= alu_overflow;
        end
        ALU_SLT, ALU_EQ: begin
          flags_q[FLG_C] <= alu_carry;
          flags_q[FLG_V] <= alu_overflow;
          flags_q[FLG_S] <= alu_size;
        end
        default: ;
      endcase
    end
  end

endmodule
